uart_rx_frame: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are set at elaboration. It reports parity, framing, break and overrun errors. Received words are presented through a valid/ready holding register, so a downstream consumer may stall without losing framing.

---
 rtl/uart_rx_frame.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with a valid/ready holding register.
// Flags parity, framing, break and overrun errors.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a falling edge
// S_START     | checking mid start bit, falls back to idle on a glitch
// S_DATA      | sampling data bits, LSB first
// S_PAR       | sampling the parity bit
// S_STOP      | sampling stop bit(s); the final sample performs the done action
// S_WAIT_HIGH | after a framing error, hold off until the line returns high
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(H);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_sync;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 all_zero_q;

  logic tick, last_stop, done, hs, load;

  assign tick      = (cnt == CNT_LAST);
  // A low stop sample ends the frame early; remaining stop bits are skipped.
  assign last_stop = ~rx_sync | (stop_idx == STOP_LAST);
  assign done      = (state == S_STOP) & tick & last_stop;
  assign hs        = o_Rx_Valid & i_Rx_Ready;
  assign load      = done & (~o_Rx_Valid | hs);
  assign o_Busy    = (state != S_IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      all_zero_q   <= 1'b0;
      o_Rx_Valid   <= 1'b0;
      o_Rx_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;

      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (!rx_sync) begin
            state      <= S_START;
            par_err_q  <= 1'b0;
            all_zero_q <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt        <= '0;
            shift_q    <= {rx_sync, shift_q[DATA_BITS-1:1]};
            all_zero_q <= all_zero_q & ~rx_sync;
            bit_idx    <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST)
              state <= (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (tick) begin
            cnt        <= '0;
            par_err_q  <= ((^shift_q) ^ rx_sync) != ODD;
            all_zero_q <= all_zero_q & ~rx_sync;
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt        <= '0;
            stop_idx   <= stop_idx + 1'b1;
            all_zero_q <= all_zero_q & ~rx_sync;
            if (!rx_sync)
              state <= S_WAIT_HIGH;
            else if (last_stop)
              state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_sync)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A load in the handshake cycle takes priority over the clear.
      if (load) begin
        o_Rx_Valid   <= 1'b1;
        o_Rx_Data    <= shift_q;
        o_Parity_Err <= par_err_q;
        o_Frame_Err  <= ~rx_sync;
        o_Break      <= all_zero_q & ~rx_sync;
      end else if (hs) begin
        o_Rx_Valid   <= 1'b0;
        o_Parity_Err <= 1'b0;
        o_Frame_Err  <= 1'b0;
        o_Break      <= 1'b0;
      end

      if (done && !load)
        o_Overrun <= 1'b1;
      else if (hs)
        o_Overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and a 7E2 instance on a shared clock.
module tb_uart_rx_frame;
  logic clk = 1'b0;
  logic rst;
  logic line_a, line_b;
  logic ready_a, ready_b;

  logic       valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic       valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;
  logic [6:0] data_b;

  int n_checks = 0;
  int n_pass   = 0;

  int         words_a = 0, words_b = 0;
  logic [7:0] last_data_a = '0;
  logic [6:0] last_data_b = '0;
  logic       last_perr_a, last_ferr_a, last_brk_a;
  logic       last_perr_b, last_ferr_b;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line_a),
    .o_Rx_Valid(valid_a), .i_Rx_Ready(ready_a), .o_Rx_Data(data_a),
    .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Break(brk_a),
    .o_Overrun(ovr_a), .o_Busy(busy_a)
  );

  uart_rx_frame #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line_b),
    .o_Rx_Valid(valid_b), .i_Rx_Ready(ready_b), .o_Rx_Data(data_b),
    .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Break(brk_b),
    .o_Overrun(ovr_b), .o_Busy(busy_b)
  );

  // Record every word the consumer accepts.
  always @(posedge clk) begin
    if (!rst && valid_a && ready_a) begin
      words_a++;
      last_data_a = data_a;
      last_perr_a = perr_a;
      last_ferr_a = ferr_a;
      last_brk_a  = brk_a;
    end
    if (!rst && valid_b && ready_b) begin
      words_b++;
      last_data_b = data_b;
      last_perr_b = perr_b;
      last_ferr_b = ferr_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive a frame LSB first, 10 clocks per bit, starting at the next falling edge.
  task automatic tx(input int which, input logic [15:0] frame, input int nbits);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (which == 0) line_a = frame[i];
      else            line_b = frame[i];
      repeat (10) @(negedge clk);
    end
    if (which == 0) line_a = 1'b1;
    else            line_b = 1'b1;
  endtask

  int w0;

  initial begin
    rst = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_valid_b", valid_b, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5: valid exactly one cycle after edge 97
    fork
      tx(0, {1'b1, 8'hA5, 1'b0}, 10);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1 check("t1_busy_mid", busy_a, 1);
        repeat (46) @(posedge clk);
        #1 check("t1_valid_e96", valid_a, 0);
        @(posedge clk);
        #1;
        check("t1_valid_e97", valid_a, 1);
        check("t1_data", data_a, 8'hA5);
        check("t1_perr", perr_a, 0);
        check("t1_ferr", ferr_a, 0);
        check("t1_brk", brk_a, 0);
        check("t1_ovr", ovr_a, 0);
        @(posedge clk);
        #1 check("t1_valid_e98", valid_a, 0);
      end
    join
    repeat (5) @(negedge clk);

    // 7E2: 0x41 has even weight, so parity bit 1 is an error and 0 is clean
    w0 = words_b;
    tx(1, {2'b11, 1'b1, 7'h41, 1'b0}, 11);
    repeat (5) @(negedge clk);
    check("t2_words_bad", words_b, w0 + 1);
    check("t2_perr_bad", last_perr_b, 1);
    check("t2_ferr_bad", last_ferr_b, 0);
    tx(1, {2'b11, 1'b0, 7'h41, 1'b0}, 11);
    repeat (5) @(negedge clk);
    check("t2_words_good", words_b, w0 + 2);
    check("t2_perr_good", last_perr_b, 0);
    check("t2_data_good", last_data_b, 7'h41);

    // Overrun: stalled consumer, second frame dropped
    w0 = words_a;
    ready_a = 1'b0;
    tx(0, {1'b1, 8'h11, 1'b0}, 10);
    tx(0, {1'b1, 8'h22, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("t3_valid", valid_a, 1);
    check("t3_data", data_a, 8'h11);
    check("t3_ovr", ovr_a, 1);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_clr", valid_a, 0);
    check("t3_ovr_clr", ovr_a, 0);
    check("t3_words", words_a, w0 + 1);
    check("t3_hs_data", last_data_a, 8'h11);
    repeat (30) @(negedge clk);
    check("t3_no_22", words_a, w0 + 1);

    // Break: line low for three frame times
    w0 = words_a;
    @(negedge clk) line_a = 1'b0;
    repeat (200) @(negedge clk);
    check("t4_busy_hold", busy_a, 1);
    repeat (100) @(negedge clk);
    line_a = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_words", words_a, w0 + 1);
    check("t4_data", last_data_a, 8'h00);
    check("t4_ferr", last_ferr_a, 1);
    check("t4_brk", last_brk_a, 1);
    repeat (50) @(negedge clk);
    check("t4_no_more", words_a, w0 + 1);
    check("t4_idle", busy_a, 0);

    // Glitch: 3-cycle low pulse is rejected
    w0 = words_a;
    @(negedge clk) line_a = 1'b0;
    repeat (3) @(negedge clk);
    line_a = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle", busy_a, 0);
    check("t5_no_word", words_a, w0);
    tx(0, {1'b1, 8'h5A, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("t5_words", words_a, w0 + 1);
    check("t5_data", last_data_a, 8'h5A);
    check("t5_ferr", last_ferr_a, 0);
    check("t5_brk", last_brk_a, 0);

    // Reset mid data bit 4, with a word held and a frame in flight
    ready_a = 1'b0;
    tx(0, {1'b1, 8'h3C, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("t6_held", data_a, 8'h3C);
    w0 = words_a;
    fork
      tx(0, {1'b1, 8'hF0, 1'b0}, 10);
      begin
        @(negedge clk);
        repeat (55) @(negedge clk);
        check("t6_busy_pre", busy_a, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_valid", valid_a, 0);
        check("t6_data", data_a, 0);
        check("t6_busy", busy_a, 0);
        check("t6_ovr", ovr_a, 0);
        check("t6_flags", {perr_a, ferr_a, brk_a}, 0);
        @(negedge clk) rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("t6_no_word", valid_a, 0);
    ready_a = 1'b1;
    tx(0, {1'b1, 8'hC3, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("t6_words", words_a, w0 + 1);
    check("t6_c3", last_data_a, 8'hC3);
    check("t6_c3_ferr", last_ferr_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
